// File: rtl/spi_slave_if_pkg.sv
// Shared constants, config layout and bit-order helpers for the SPI responder.
package spi_slave_if_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DOUT_W     = BYTE_W + 1;
    localparam int unsigned STATUS_W   = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam int unsigned CFG_CPHA_BIT   = 0;
    localparam int unsigned CFG_CPOL_BIT   = 1;
    localparam int unsigned CFG_ENDIAN_BIT = 2;

    localparam logic ENDIAN_MSB_FIRST = 1'b0;
    localparam logic ENDIAN_LSB_FIRST = 1'b1;

    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_BUSY     = 2;
    localparam int unsigned ST_OVERRUN  = 3;

    localparam logic [BYTE_W-1:0] FILL_BYTE_DEFAULT = 8'hFF;

    typedef struct packed {
        logic endian;
        logic cpol;
        logic cpha;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{endian: ENDIAN_MSB_FIRST, cpol: 1'b0, cpha: 1'b0};

    function automatic logic [BYTE_W-1:0] bit_rev(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            r[i] = b[int'(BYTE_W) - 1 - i];
        end
        return r;
    endfunction

    // The shift registers always run MSB-first; LSB-first bytes are mirrored at the edges.
    function automatic logic [BYTE_W-1:0] order_byte(input logic endian,
                                                     input logic [BYTE_W-1:0] b);
        return (endian == ENDIAN_LSB_FIRST) ? bit_rev(b) : b;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser with edge detect against the previous synchronised sample.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] pipe;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0], d};
            prev <= pipe[SYNC_STAGES-1];
        end
    end

    assign q      = pipe[SYNC_STAGES-1];
    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/srl_fifo.sv
// Shift-register FIFO: push shifts into slot 0, head sits at slot count-1.
module srl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push shifts into.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign dout  = mem[AW'(count - CNT_W'(1))];

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder: synchronised SCK/SS/MOSI, all four modes, both bit orders,
// TX/RX byte FIFOs behind the cmd/wr/rd/ack bus.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   din,
    input  logic                cmd,
    input  logic                wr,
    input  logic                rd,
    output logic [DOUT_W-1:0]   dout,
    output logic                ack,
    output logic [STATUS_W-1:0] status,
    input  logic                spi_sck,
    input  logic                spi_ss,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe
);

    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  ACTIVE = 1'b1;
    localparam int unsigned CNT_W  = 3;

    logic [0:0]             state, state_d;
    cfg_t                   cfg;
    logic [BYTE_W-1:0]      tx_shr, tx_shr_d;
    logic [BYTE_W-1:0]      rx_shr, rx_shr_d;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_d;
    logic                   first, first_d;
    logic                   rx_push_q, rx_push_d;
    logic [BYTE_W-1:0]      rx_byte_q, rx_byte_d;
    logic                   overrun;

    logic                   sck_q, sck_rise, sck_fall;
    logic                   ss_q, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   mosi_q;

    logic                   tx_push_c, tx_pop_c, rx_pop_c;
    logic [BYTE_W-1:0]      tx_head, rx_head;
    logic                   tx_empty, tx_full, rx_empty, rx_full;

    logic                   sck_edge_c, sck_lead_c, sck_trail_c;
    logic                   sample_c, shift_c;
    logic [BYTE_W-1:0]      next_tx_c, rx_next_c;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi_sck),
        .q      (sck_q),
        .rise_c (sck_rise),
        .fall_c (sck_fall)
    );

    // SS resets high so the responder comes out of reset deselected.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi_ss),
        .q      (ss_q),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_pipe <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
        end
    end
    assign mosi_q = mosi_pipe[SYNC_STAGES-1];

    srl_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_c),
        .din   (din),
        .pop   (tx_pop_c),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    srl_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_q),
        .din   (rx_byte_q),
        .pop   (rx_pop_c),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign tx_push_c = wr & ~tx_full;
    assign rx_pop_c  = rd & ~rx_empty;
    assign dout      = rx_pop_c ? {1'b0, rx_head} : {1'b1, {BYTE_W{1'b0}}};

    // Leading edge leaves the idle level (CPOL); CPHA picks which class samples.
    assign sck_edge_c  = sck_rise | sck_fall;
    assign sck_lead_c  = sck_edge_c & (sck_q ^ cfg.cpol);
    assign sck_trail_c = sck_edge_c & ~(sck_q ^ cfg.cpol);
    assign sample_c    = cfg.cpha ? sck_trail_c : sck_lead_c;
    assign shift_c     = cfg.cpha ? sck_lead_c  : sck_trail_c;

    assign next_tx_c = order_byte(cfg.endian, tx_empty ? FILL_BYTE : tx_head);
    assign rx_next_c = {rx_shr[BYTE_W-2:0], mosi_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        tx_shr_d  = tx_shr;
        rx_shr_d  = rx_shr;
        bit_cnt_d = bit_cnt;
        first_d   = first;
        rx_push_d = 1'b0;
        rx_byte_d = rx_byte_q;
        tx_pop_c  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    tx_shr_d  = next_tx_c;
                    tx_pop_c  = ~tx_empty;
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    first_d   = 1'b0;
                end else if (sample_c) begin
                    rx_shr_d  = rx_next_c;
                    bit_cnt_d = CNT_W'(bit_cnt + CNT_W'(1));
                    first_d   = 1'b0;
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        rx_push_d = 1'b1;
                        rx_byte_d = order_byte(cfg.endian, rx_next_c);
                    end
                end else if (shift_c) begin
                    // Only a CPHA=1 frame sees a shift edge before any sample.
                    if (first) begin
                        first_d = 1'b0;
                    end else if (bit_cnt == '0) begin
                        tx_shr_d = next_tx_c;
                        tx_pop_c = ~tx_empty;
                    end else begin
                        tx_shr_d = {tx_shr[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shr    <= '0;
            rx_shr    <= '0;
            bit_cnt   <= '0;
            first     <= 1'b0;
            rx_push_q <= 1'b0;
            rx_byte_q <= '0;
            spi_miso  <= 1'b0;
        end else begin
            tx_shr    <= tx_shr_d;
            rx_shr    <= rx_shr_d;
            bit_cnt   <= bit_cnt_d;
            first     <= first_d;
            rx_push_q <= rx_push_d;
            rx_byte_q <= rx_byte_d;
            spi_miso  <= (state == ACTIVE) & tx_shr[BYTE_W-1];
        end
    end

    // Config, overrun flag and bus acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg     <= CFG_RESET;
            overrun <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= tx_push_c | rd | cmd;
            if (cmd) begin
                cfg <= '{endian: din[CFG_ENDIAN_BIT],
                         cpol:   din[CFG_CPOL_BIT],
                         cpha:   din[CFG_CPHA_BIT]};
            end
            if (rx_push_q && rx_full && !rx_pop_c) begin
                overrun <= 1'b1;
            end else if (cmd) begin
                overrun <= 1'b0;
            end
        end
    end

    assign spi_miso_oe = ~ss_q;

    always_comb begin
        status              = '0;
        status[ST_OVERRUN]  = overrun;
        status[ST_BUSY]     = (state == ACTIVE);
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: drives an SPI master model and the byte bus.
module tb_spi_slave_if;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       cmd, wr, rd;
    logic [8:0] dout;
    logic       ack;
    logic [3:0] status;
    logic       spi_sck, spi_ss, spi_mosi;
    logic       spi_miso, spi_miso_oe;

    int n_checks;
    int n_pass;
    int half;
    logic cur_cpol, cur_cpha;

    spi_slave_if dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .cmd         (cmd),
        .wr          (wr),
        .rd          (rd),
        .dout        (dout),
        .ack         (ack),
        .status      (status),
        .spi_sck     (spi_sck),
        .spi_ss      (spi_ss),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_cmd(input logic [7:0] c);
        @(negedge clk);
        din = c;
        cmd = 1'b1;
        @(negedge clk);
        cmd = 1'b0;
        cur_cpha = c[0];
        cur_cpol = c[1];
    endtask

    task automatic bus_wr(input logic [7:0] b, output logic a);
        @(negedge clk);
        din = b;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        a  = ack;
    endtask

    task automatic bus_rd(output logic [8:0] d, output logic a);
        @(negedge clk);
        rd = 1'b1;
        #1 d = dout;
        @(negedge clk);
        rd = 1'b0;
        a  = ack;
    endtask

    task automatic ss_low();
        spi_sck = cur_cpol;
        wait_clk(half);
        spi_ss = 1'b0;
        wait_clk(half);
    endtask

    task automatic ss_high();
        wait_clk(half);
        spi_ss = 1'b1;
        wait_clk(half + 4);
    endtask

    // Master side: wire bits go out mo[7] first; miso captured at the master's sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cur_cpha) begin
                spi_mosi = mo[7-i];
                wait_clk(half);
                mi[7-i] = spi_miso;
                spi_sck = ~cur_cpol;
                wait_clk(half);
                spi_sck = cur_cpol;
            end else begin
                spi_sck  = ~cur_cpol;
                spi_mosi = mo[7-i];
                wait_clk(half);
                mi[7-i] = spi_miso;
                spi_sck = cur_cpol;
                wait_clk(half);
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [8:0] rdv;
        logic       a;
        logic [7:0] tx_bytes [4];

        n_checks = 0;
        n_pass   = 0;
        half     = 8;
        cur_cpol = 1'b0;
        cur_cpha = 1'b0;
        rst = 1'b1; din = '0; cmd = 1'b0; wr = 1'b0; rd = 1'b0;
        spi_sck = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;

        wait_clk(3);
        check("rst_status", 16'(status), 16'h3);
        check("rst_miso", 16'(spi_miso), 16'h0);
        check("rst_oe", 16'(spi_miso_oe), 16'h0);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_dout", 16'(dout), 16'h100);
        rst = 1'b0;
        wait_clk(6);

        // Mode 0, MSB first
        bus_cmd(8'h00);
        bus_wr(8'hA5, a);
        check("m0_wr_ack", 16'(a), 16'h1);
        check("m0_status_txq", 16'(status), 16'h1);
        ss_low();
        check("m0_busy", 16'(status), 16'h7);
        check("m0_oe", 16'(spi_miso_oe), 16'h1);
        xfer(8'h3C, 8, mi);
        ss_high();
        check("m0_miso", 16'(mi), 16'hA5);
        check("m0_status_rx", 16'(status), 16'h2);
        bus_rd(rdv, a);
        check("m0_rd", 16'(rdv), 16'h03C);
        check("m0_rd_ack", 16'(a), 16'h1);

        // Mode 3, LSB first
        bus_cmd(8'h07);
        bus_wr(8'h01, a);
        ss_low();
        xfer(8'h80, 8, mi);
        ss_high();
        check("m3_miso", 16'(mi), 16'h80);
        bus_rd(rdv, a);
        check("m3_rd", 16'(rdv), 16'h001);

        // Mode 1, TX empty, two-byte frame
        bus_cmd(8'h01);
        ss_low();
        xfer(8'h12, 8, mi);
        check("m1_miso0", 16'(mi), 16'hFF);
        xfer(8'h34, 8, mi);
        check("m1_miso1", 16'(mi), 16'hFF);
        ss_high();
        check("m1_status", 16'(status), 16'h2);
        bus_rd(rdv, a);
        check("m1_rd0", 16'(rdv), 16'h012);
        bus_rd(rdv, a);
        check("m1_rd1", 16'(rdv), 16'h034);
        bus_rd(rdv, a);
        check("m1_rd_empty", 16'(rdv), 16'h100);
        check("m1_rd_empty_ack", 16'(a), 16'h1);

        // TX FIFO full: fifth write is refused
        bus_cmd(8'h00);
        tx_bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int k = 0; k < 4; k++) begin
            bus_wr(tx_bytes[k], a);
            check("txf_wr_ack", 16'(a), 16'h1);
        end
        bus_wr(8'h50, a);
        check("txf_full_ack", 16'(a), 16'h0);
        check("txf_status", 16'(status), 16'h1);
        ss_low();
        for (int k = 0; k < 4; k++) begin
            xfer(8'(k + 1), 8, mi);
            check("txf_miso", 16'(mi), 16'(tx_bytes[k]));
        end
        ss_high();
        check("txf_status_end", 16'(status), 16'h2);
        for (int k = 0; k < 4; k++) begin
            bus_rd(rdv, a);
            check("txf_rd", 16'(rdv), 16'(k + 1));
        end

        // RX overrun: five one-byte frames into a 4-deep FIFO
        for (int k = 0; k < 5; k++) begin
            ss_low();
            xfer(8'(8'h11 * (k + 1)), 8, mi);
            ss_high();
            if (k == 3) check("ovr_status_full", 16'(status), 16'h2);
        end
        check("ovr_status_set", 16'(status), 16'hA);
        bus_cmd(8'h00);
        check("ovr_status_clr", 16'(status), 16'h2);
        for (int k = 0; k < 4; k++) begin
            bus_rd(rdv, a);
            check("ovr_rd", 16'(rdv), 16'(8'(8'h11 * (k + 1))));
        end
        bus_rd(rdv, a);
        check("ovr_rd_empty", 16'(rdv), 16'h100);

        // Partial byte then ss rise: nothing pushed, next frame intact
        bus_wr(8'hC3, a);
        ss_low();
        xfer(8'hA0, 4, mi);
        ss_high();
        check("part_status", 16'(status), 16'h3);
        bus_wr(8'h5A, a);
        ss_low();
        xfer(8'h96, 8, mi);
        ss_high();
        check("part_miso", 16'(mi), 16'h5A);
        bus_rd(rdv, a);
        check("part_rd", 16'(rdv), 16'h096);

        // Reset mid-byte in mode 2
        bus_cmd(8'h02);
        bus_wr(8'hE7, a);
        ss_low();
        xfer(8'hB0, 4, mi);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2_miso", 16'(spi_miso), 16'h0);
        check("rst2_oe", 16'(spi_miso_oe), 16'h0);
        check("rst2_status", 16'(status), 16'h3);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        bus_cmd(8'h02);
        ss_high();
        check("rst2_status_idle", 16'(status), 16'h3);
        bus_wr(8'h81, a);
        ss_low();
        xfer(8'h7E, 8, mi);
        ss_high();
        check("rst2_miso_next", 16'(mi), 16'h81);
        bus_rd(rdv, a);
        check("rst2_rd", 16'(rdv), 16'h07E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
